// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step unsigned MUL/MULHU/DIVU/REMU sequencer for EX.
// The unit stalls the pipeline while it is busy, then pulses ready_o for one cycle.
module muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  hi_q;
  logic [DATA_W-1:0]     a_q, b_q, q_q, r_q, result_q;
  logic [2*DATA_W-1:0]   p_q, p_d;
  logic [DATA_W:0]       mul_sum, r_sh;
  logic [DATA_W-1:0]     q_d, r_d;
  logic                  ge;
  always_comb begin
    mul_sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + {1'b0, p_q[0] ? a_q : '0};
    p_d     = {mul_sum, p_q[DATA_W-1:1]};
    r_sh    = {r_q, q_q[DATA_W-1]};
    ge      = r_sh >= {1'b0, b_q};
    r_d     = ge ? DATA_W'(r_sh - {1'b0, b_q}) : r_sh[DATA_W-1:0];
    q_d     = {q_q[DATA_W-2:0], ge};
  end
  // hi_q selects the upper product for MUL ops and the remainder for DIV ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) state_q <= IDLE;
      else case (state_q)
        IDLE: if (start_i) begin
          hi_q    <= op_i[0];
          a_q     <= opa_i;
          b_q     <= opb_i;
          cnt_q   <= '0;
          p_q     <= {{DATA_W{1'b0}}, opb_i};
          q_q     <= opa_i;
          r_q     <= '0;
          state_q <= op_i[1] ? DIV : MUL;
        end
        MUL: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q  <= DONE;
            result_q <= hi_q ? p_d[2*DATA_W-1:DATA_W] : p_d[DATA_W-1:0];
            ready_o  <= 1'b1;
          end
        end
        DIV: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q  <= DONE;
            result_q <= hi_q ? r_d : q_d;
            ready_o  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign result_o = result_q;
  assign stall_o  = (state_q == IDLE && start_i && !annul_i) || state_q == MUL || state_q == DIV;
endmodule
